// File: rtl/core_pkg.sv
// Shared definitions for the writeback stage and the load-extension helper.
package core_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/core_load_ext.sv
// Load data selection and sign/zero extension, plus width/alignment legality.
// Purely combinational so the LSU can reuse it for misalignment checks.
module core_load_ext
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to funct3.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = rdata;
    illegal  = 1'b0;
    case (funct3)
      LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LBU: data = {24'd0, byte_sel};
      LH: begin
        data    = {{16{half_sel[15]}}, half_sel};
        illegal = addr_lo[0];
      end
      LHU: begin
        data    = {16'd0, half_sel};
        illegal = addr_lo[0];
      end
      LW:      illegal = (addr_lo != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_wb.sv
// Writeback stage: accepts one retiring instruction, waits for load data when
// needed, and drives the register array write port for one cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a new instruction from execute
// WAIT_MEM | load accepted, waiting for mem_rvalid or the timeout
// WRITE    | result latched; registered write/retire outputs load this edge
module core_wb
  import core_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_rd_wen,
  input  logic [4:0]       ex_rd_addr,
  input  logic [31:0]      ex_result,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_funct3,
  input  logic [1:0]       ex_addr_lo,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_err,
  output logic             rf_wen,
  output logic [4:0]       rf_rd_addr,
  output logic [31:0]      rf_rd_din,
  output logic             wb_done,
  output logic             wb_err,
  output logic             busy,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  wb_state_t   state, state_next;
  logic        rd_wen_q;
  logic [4:0]  rd_addr_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] result_q;
  logic [TW-1:0] tmo_cnt;

  logic [31:0] ld_data;
  logic        ld_illegal;
  logic        wen_next, done_next, err_next, load_take;

  // Legality is a function of the accepted funct3/addr_lo only, so evaluating
  // it on the latched copies matches the decision made at accept.
  core_load_ext u_load_ext (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (mem_rdata),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  assign ex_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and next values of the registered pulse outputs.
  always_comb begin
    state_next = state;
    wen_next   = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    load_take  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) state_next = ex_is_load ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        // A response arriving on the threshold cycle takes priority.
        if (mem_rvalid) begin
          if (mem_err || ld_illegal) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            load_take  = 1'b1;
            state_next = WRITE;
          end
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        done_next  = 1'b1;
        wen_next   = rd_wen_q && (rd_addr_q != 5'd0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Instruction capture, timeout counter, output registers and retire count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_wen_q   <= 1'b0;
      rd_addr_q  <= 5'd0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      result_q   <= 32'd0;
      tmo_cnt    <= '0;
      rf_wen     <= 1'b0;
      rf_rd_addr <= 5'd0;
      rf_rd_din  <= 32'd0;
      wb_done    <= 1'b0;
      wb_err     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (state == IDLE && ex_valid) begin
        rd_wen_q  <= ex_rd_wen;
        rd_addr_q <= ex_rd_addr;
        funct3_q  <= ex_funct3;
        addr_lo_q <= ex_addr_lo;
        result_q  <= ex_result;
        tmo_cnt   <= '0;
      end
      if (state == WAIT_MEM && !mem_rvalid) tmo_cnt <= tmo_cnt + TW'(1);
      if (load_take) result_q <= ld_data;
      rf_wen  <= wen_next;
      wb_done <= done_next;
      wb_err  <= err_next;
      if (done_next) begin
        rf_rd_addr <= rd_addr_q;
        rf_rd_din  <= result_q;
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_wb.sv
// Directed bench for core_wb with a short timeout so the abandon path is quick.
module tb_core_wb;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_rd_wen, ex_is_load;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        rf_wen, wb_done, wb_err, busy;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_din;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  core_wb #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd_wen  (ex_rd_wen),
    .ex_rd_addr (ex_rd_addr),
    .ex_result  (ex_result),
    .ex_is_load (ex_is_load),
    .ex_funct3  (ex_funct3),
    .ex_addr_lo (ex_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .rf_wen     (rf_wen),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_din  (rf_rd_din),
    .wb_done    (wb_done),
    .wb_err     (wb_err),
    .busy       (busy),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] cnt);
    chk1({tag, "_rf_wen"}, rf_wen, 1'b0);
    chk1({tag, "_wb_done"}, wb_done, 1'b0);
    chk1({tag, "_wb_err"}, wb_err, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_ex_ready"}, ex_ready, 1'b1);
    chk32({tag, "_retire"}, retire_cnt, cnt);
  endtask

  // Drives a non-load accept; returns just after the accept edge.
  task automatic issue_alu(input logic wen, input logic [4:0] rd, input logic [31:0] res);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd_wen = wen; ex_rd_addr = rd; ex_result = res;
    tick();
    ex_valid = 1'b0; ex_result = 32'hDEAD_BEEF;
  endtask

  // Accepts a load, waits the given cycles, then presents one response.
  // Returns just after the edge that samples the response.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic err, input int waits);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = f3; ex_addr_lo = lo;
    ex_rd_addr = rd; ex_rd_wen = 1'b1; ex_result = 32'h5555_5555;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_funct3 = 3'b111; ex_addr_lo = 2'b11;
    repeat (waits) tick();
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_rd_wen = 1'b0; ex_rd_addr = 5'd0; ex_result = 32'd0;
    ex_is_load = 1'b0; ex_funct3 = 3'd0; ex_addr_lo = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
    tick(); tick();

    // Reset values
    chk_idle_outputs("reset", 32'd0);
    chk32("reset_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
    chk32("reset_rd_din", rf_rd_din, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD retire to x5
    issue_alu(1'b1, 5'd5, 32'h1234_5678);
    chk1("add_busy", busy, 1'b1);
    chk1("add_not_ready", ex_ready, 1'b0);
    chk1("add_no_early_wen", rf_wen, 1'b0);
    tick();
    chk1("add_rf_wen", rf_wen, 1'b1);
    chk32("add_rd_addr", {27'd0, rf_rd_addr}, 32'd5);
    chk32("add_rd_din", rf_rd_din, 32'h1234_5678);
    chk1("add_wb_done", wb_done, 1'b1);
    chk32("add_retire", retire_cnt, 32'd1);
    chk1("add_ready_again", ex_ready, 1'b1);

    // Back-to-back accept: x0 destination retires without a write
    issue_alu(1'b1, 5'd0, 32'hABCD_0000);
    chk1("add_pulse_ends", wb_done, 1'b0);
    tick();
    chk1("x0_rf_wen", rf_wen, 1'b0);
    chk1("x0_wb_done", wb_done, 1'b1);
    chk32("x0_retire", retire_cnt, 32'd2);

    // rd_wen=0 retires without a write
    issue_alu(1'b0, 5'd9, 32'h0000_0001);
    tick();
    chk1("nowen_rf_wen", rf_wen, 1'b0);
    chk1("nowen_wb_done", wb_done, 1'b1);
    chk32("nowen_retire", retire_cnt, 32'd3);
    tick();

    // LB sign-extend, byte 3, two wait cycles
    do_load(LB, 2'd3, 5'd7, 32'h80FF_0000, 1'b0, 2);
    chk1("lb_busy_write", busy, 1'b1);
    tick();
    chk1("lb_rf_wen", rf_wen, 1'b1);
    chk32("lb_rd_addr", {27'd0, rf_rd_addr}, 32'd7);
    chk32("lb_rd_din", rf_rd_din, 32'hFFFF_FF80);
    chk32("lb_retire", retire_cnt, 32'd4);
    tick();

    // Stray response while IDLE is ignored
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    chk_idle_outputs("stray", 32'd4);

    // LHU upper half, fastest response
    do_load(LHU, 2'd2, 5'd9, 32'h8001_0000, 1'b0, 0);
    tick();
    chk1("lhu_rf_wen", rf_wen, 1'b1);
    chk32("lhu_rd_din", rf_rd_din, 32'h0000_8001);
    chk32("lhu_retire", retire_cnt, 32'd5);
    tick();

    // LH lower half sign-extend
    do_load(LH, 2'd0, 5'd10, 32'h1234_F00F, 1'b0, 1);
    tick();
    chk32("lh_rd_din", rf_rd_din, 32'hFFFF_F00F);
    tick();

    // LBU byte 1 zero-extend
    do_load(LBU, 2'd1, 5'd11, 32'h0000_9A00, 1'b0, 0);
    tick();
    chk32("lbu_rd_din", rf_rd_din, 32'h0000_009A);
    chk32("lbu_retire", retire_cnt, 32'd7);
    tick();

    // Misaligned LW: error pulse, no write
    do_load(LW, 2'd1, 5'd12, 32'h1111_1111, 1'b0, 1);
    chk1("lwmis_wb_err", wb_err, 1'b1);
    chk1("lwmis_rf_wen", rf_wen, 1'b0);
    chk1("lwmis_ready", ex_ready, 1'b1);
    tick();
    chk_idle_outputs("lwmis_after", 32'd7);

    // Illegal funct3 011
    do_load(3'b011, 2'd0, 5'd12, 32'h1111_1111, 1'b0, 0);
    chk1("f3ill_wb_err", wb_err, 1'b1);
    tick();

    // Bus error
    do_load(LW, 2'd0, 5'd13, 32'h2222_2222, 1'b1, 1);
    chk1("memerr_wb_err", wb_err, 1'b1);
    chk1("memerr_rf_wen", rf_wen, 1'b0);
    tick();
    chk_idle_outputs("memerr_after", 32'd7);

    // Timeout: no response for 4 WAIT_MEM cycles
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = LW; ex_addr_lo = 2'd0; ex_rd_addr = 5'd14;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick(); tick(); tick();
    chk1("tmo_pre_err", wb_err, 1'b0);
    chk1("tmo_pre_busy", busy, 1'b1);
    tick();
    chk1("tmo_wb_err", wb_err, 1'b1);
    chk1("tmo_ready", ex_ready, 1'b1);
    chk1("tmo_rf_wen", rf_wen, 1'b0);
    tick();
    chk_idle_outputs("tmo_after", 32'd7);

    // Response on the threshold cycle wins over timeout
    do_load(LW, 2'd0, 5'd15, 32'hCAFE_F00D, 1'b0, 3);
    chk1("race_no_err", wb_err, 1'b0);
    tick();
    chk1("race_rf_wen", rf_wen, 1'b1);
    chk32("race_rd_din", rf_rd_din, 32'hCAFE_F00D);
    chk32("race_retire", retire_cnt, 32'd8);
    tick();

    // Reset during WAIT_MEM, then a late response
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = LW; ex_addr_lo = 2'd0; ex_rd_addr = 5'd16;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk_idle_outputs("rstmid", 32'd0);
    chk32("rstmid_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
    chk32("rstmid_rd_din", rf_rd_din, 32'd0);

    // Reset while in WRITE suppresses the write
    issue_alu(1'b1, 5'd3, 32'h0BAD_0BAD);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("rstwr_rf_wen", rf_wen, 1'b0);
    chk1("rstwr_wb_done", wb_done, 1'b0);
    chk32("rstwr_rd_din", rf_rd_din, 32'd0);
    tick();
    chk_idle_outputs("rstwr_after", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
